// File: rtl/y86_pkg.sv
// Y86-64 instruction encoding helpers shared by the loader-side byte serializer.
// Lengths and field presence follow the fetch-stage byte layout.
package y86_pkg;

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_CMOVXX = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   localparam logic [3:0] LEN_1  = 4'd1;
   localparam logic [3:0] LEN_2  = 4'd2;
   localparam logic [3:0] LEN_9  = 4'd9;
   localparam logic [3:0] LEN_10 = 4'd10;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EMIT = 1'b1
   } state_t;

   function automatic logic icode_valid(input logic [3:0] icode);
      return icode <= I_POPQ;
   endfunction

   function automatic logic [3:0] instr_len(input logic [3:0] icode);
      logic [3:0] len;
      len = LEN_1;
      case (icode)
         I_HALT, I_NOP, I_RET:               len = LEN_1;
         I_CMOVXX, I_OPQ, I_PUSHQ, I_POPQ:   len = LEN_2;
         I_JXX, I_CALL:                      len = LEN_9;
         I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:       len = LEN_10;
         default:                            len = LEN_1;
      endcase
      return len;
   endfunction

   function automatic logic has_regs(input logic [3:0] icode);
      return (instr_len(icode) == LEN_2) || (instr_len(icode) == LEN_10);
   endfunction

   // Byte index where valC starts; 0 means the instruction carries no valC.
   function automatic logic [3:0] valc_base(input logic [3:0] icode);
      logic [3:0] base;
      base = 4'd0;
      if (instr_len(icode) == LEN_9)  base = 4'd1;
      if (instr_len(icode) == LEN_10) base = 4'd2;
      return base;
   endfunction

endpackage

// File: rtl/instr_byte_sel.sv
// Combinational byte picker: instruction fields plus byte index -> encoded byte.
// Single home of the byte layout so it stays aligned with fetch.
module instr_byte_sel
   import y86_pkg::*;
(
   input  logic [3:0]  icode_i,
   input  logic [3:0]  ifun_i,
   input  logic [3:0]  ra_i,
   input  logic [3:0]  rb_i,
   input  logic [63:0] valc_i,
   input  logic [3:0]  idx_i,
   output logic [7:0]  data_o
);

   logic [3:0] vbase;
   logic [3:0] voff;
   logic [7:0] vbyte;

   always_comb begin
      vbase = valc_base(icode_i);
      voff  = idx_i - vbase;
      // Out-of-range offsets (including wrap when idx < vbase) fall to default.
      case (voff)
         4'd0:    vbyte = valc_i[7:0];
         4'd1:    vbyte = valc_i[15:8];
         4'd2:    vbyte = valc_i[23:16];
         4'd3:    vbyte = valc_i[31:24];
         4'd4:    vbyte = valc_i[39:32];
         4'd5:    vbyte = valc_i[47:40];
         4'd6:    vbyte = valc_i[55:48];
         4'd7:    vbyte = valc_i[63:56];
         default: vbyte = 8'h00;
      endcase
   end

   always_comb begin
      data_o = 8'h00;
      if (idx_i == 4'd0) begin
         data_o = {icode_i, ifun_i};
      end else if ((idx_i == 4'd1) && has_regs(icode_i)) begin
         data_o = {ra_i, rb_i};
      end else if (vbase != 4'd0) begin
         data_o = vbyte;
      end
   end

endmodule

// File: rtl/imem_writer.sv
// Accepts decoded Y86-64 instruction fields and writes their encoded bytes,
// one per cycle, into instruction memory at an auto-advancing write pointer.
module imem_writer
   import y86_pkg::*;
#(
   parameter int ADDR_W    = 64,
   parameter int MEM_BYTES = 2048
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              base_load,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        icode,
   input  logic [3:0]        ifun,
   input  logic [3:0]        rA,
   input  logic [3:0]        rB,
   input  logic [63:0]       valC,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic              done,
   output logic              instr_err,
   output logic              mem_err,
   output logic [ADDR_W-1:0] next_addr,
   output logic              dbg_state
);

   // Handshake: a transfer happens on a rising edge where in_valid && in_ready.
   // in_ready is high only in IDLE with no base_load; fields must hold while
   // in_valid is high and not yet accepted.

   localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);

   state_t            state_q, state_d;
   logic [3:0]        k_q, k_d;
   logic [3:0]        icode_q, icode_d;
   logic [3:0]        ifun_q, ifun_d;
   logic [3:0]        ra_q, ra_d;
   logic [3:0]        rb_q, rb_d;
   logic [63:0]       valc_q, valc_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [7:0]        wr_data_q, wr_data_d;
   logic              done_q, done_d;
   logic              instr_err_q, instr_err_d;
   logic              mem_err_q, mem_err_d;

   logic              accept;
   logic              overrun;
   logic [3:0]        in_len;
   logic [3:0]        cur_len;
   logic [3:0]        k_nxt;
   logic [3:0]        sel_icode, sel_ifun, sel_ra, sel_rb, sel_idx;
   logic [63:0]       sel_valc;
   logic [7:0]        sel_data;

   assign in_ready = (state_q == ST_IDLE) && !base_load;
   assign accept   = in_valid && in_ready;
   assign in_len   = instr_len(icode);
   assign cur_len  = instr_len(icode_q);
   assign k_nxt    = k_q + 4'd1;
   // One extra bit so pointer + length cannot wrap past the limit.
   assign overrun  = ({1'b0, ptr_q} + {{(ADDR_W-3){1'b0}}, in_len}) > MEM_LIMIT;

   // Byte 0 comes straight from the inputs on accept; later bytes from the latch.
   always_comb begin
      if (state_q == ST_IDLE) begin
         sel_icode = icode;
         sel_ifun  = ifun;
         sel_ra    = rA;
         sel_rb    = rB;
         sel_valc  = valC;
         sel_idx   = 4'd0;
      end else begin
         sel_icode = icode_q;
         sel_ifun  = ifun_q;
         sel_ra    = ra_q;
         sel_rb    = rb_q;
         sel_valc  = valc_q;
         sel_idx   = k_nxt;
      end
   end

   instr_byte_sel u_byte_sel (
      .icode_i (sel_icode),
      .ifun_i  (sel_ifun),
      .ra_i    (sel_ra),
      .rb_i    (sel_rb),
      .valc_i  (sel_valc),
      .idx_i   (sel_idx),
      .data_o  (sel_data)
   );

   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      icode_d     = icode_q;
      ifun_d      = ifun_q;
      ra_d        = ra_q;
      rb_d        = rb_q;
      valc_d      = valc_q;
      ptr_d       = ptr_q;
      wr_en_d     = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = 8'h00;
      done_d      = 1'b0;
      instr_err_d = 1'b0;
      mem_err_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (base_load) begin
               ptr_d = base_addr;
            end else if (accept) begin
               if (!icode_valid(icode)) begin
                  instr_err_d = 1'b1;
               end else if (overrun) begin
                  mem_err_d = 1'b1;
               end else begin
                  icode_d   = icode;
                  ifun_d    = ifun;
                  ra_d      = rA;
                  rb_d      = rB;
                  valc_d    = valC;
                  k_d       = 4'd0;
                  wr_en_d   = 1'b1;
                  wr_addr_d = ptr_q;
                  wr_data_d = sel_data;
                  done_d    = (in_len == LEN_1);
                  state_d   = ST_EMIT;
               end
            end
         end
         ST_EMIT: begin
            // k_q is the byte currently on the write port.
            if (k_q == cur_len - 4'd1) begin
               ptr_d   = ptr_q + {{(ADDR_W-4){1'b0}}, cur_len};
               state_d = ST_IDLE;
            end else begin
               k_d       = k_nxt;
               wr_en_d   = 1'b1;
               wr_addr_d = ptr_q + {{(ADDR_W-4){1'b0}}, k_nxt};
               wr_data_d = sel_data;
               done_d    = (k_nxt == cur_len - 4'd1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         k_q         <= 4'd0;
         icode_q     <= 4'd0;
         ifun_q      <= 4'd0;
         ra_q        <= 4'd0;
         rb_q        <= 4'd0;
         valc_q      <= 64'd0;
         ptr_q       <= '0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= 8'h00;
         done_q      <= 1'b0;
         instr_err_q <= 1'b0;
         mem_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         icode_q     <= icode_d;
         ifun_q      <= ifun_d;
         ra_q        <= ra_d;
         rb_q        <= rb_d;
         valc_q      <= valc_d;
         ptr_q       <= ptr_d;
         wr_en_q     <= wr_en_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         done_q      <= done_d;
         instr_err_q <= instr_err_d;
         mem_err_q   <= mem_err_d;
      end
   end

   assign wr_en     = wr_en_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign done      = done_q;
   assign instr_err = instr_err_q;
   assign mem_err   = mem_err_q;
   assign next_addr = ptr_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_imem_writer.sv
// Directed bench for imem_writer: a per-cycle expected-event queue built from the
// instruction byte layout, checked every cycle, plus literal memory-image checks.
module tb_imem_writer;

   logic        clk = 1'b0;
   logic        rst, base_load, in_valid;
   logic [63:0] base_addr, valC;
   logic [3:0]  icode, ifun, rA, rB;
   logic        in_ready, wr_en, done, instr_err, mem_err, dbg_state;
   logic [63:0] wr_addr, next_addr;
   logic [7:0]  wr_data;

   always #5 clk = ~clk;

   imem_writer #(.ADDR_W(64), .MEM_BYTES(2048)) dut (
      .clk       (clk),
      .rst       (rst),
      .base_load (base_load),
      .base_addr (base_addr),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .icode     (icode),
      .ifun      (ifun),
      .rA        (rA),
      .rB        (rB),
      .valC      (valC),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .done      (done),
      .instr_err (instr_err),
      .mem_err   (mem_err),
      .next_addr (next_addr),
      .dbg_state (dbg_state)
   );

   typedef struct {
      logic        we;
      logic [63:0] addr;
      logic [7:0]  data;
      logic        dn;
      logic        ierr;
      logic        merr;
      logic        rdy;
      logic [63:0] nxt;
   } ev_t;

   ev_t         exp_q[$];
   logic [7:0]  bq[$];
   logic [63:0] m_ptr = '0;
   bit          check_en = 1'b0;
   int          n_vec = 0, n_err = 0, cyc = 0;
   int          wr_cnt = 0, done_cnt = 0, ierr_cnt = 0, merr_cnt = 0;
   logic [7:0]  mem_img [longint];
   int          wcyc [longint];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic ev_t mk_ev(logic we, logic [63:0] addr, logic [7:0] data, logic dn,
                                 logic ie, logic me, logic rdy, logic [63:0] nxt);
      ev_t e;
      e.we = we; e.addr = addr; e.data = data; e.dn = dn;
      e.ierr = ie; e.merr = me; e.rdy = rdy; e.nxt = nxt;
      return e;
   endfunction

   // Model: on an accepted instruction, queue one event per future cycle.
   // The trailing idle event is the cycle the writer spends returning to IDLE.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst) begin
         exp_q.delete();
         m_ptr    <= '0;
         check_en <= 1'b1;
      end else if (exp_q.size() == 0) begin
         if (base_load) begin
            m_ptr <= base_addr;
         end else if (in_valid) begin
            if (icode > 4'hB) begin
               exp_q.push_back(mk_ev(1'b0, '0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, m_ptr));
            end else begin
               bq.delete();
               bq.push_back({icode, ifun});
               if (icode inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB})
                  bq.push_back({rA, rB});
               if (icode inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8})
                  for (int i = 0; i < 8; i++) bq.push_back(valC[8*i +: 8]);
               if (({1'b0, m_ptr} + 65'(bq.size())) > 65'd2048) begin
                  exp_q.push_back(mk_ev(1'b0, '0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, m_ptr));
               end else begin
                  for (int k = 0; k < bq.size(); k++)
                     exp_q.push_back(mk_ev(1'b1, m_ptr + 64'(k), bq[k], (k == bq.size() - 1),
                                           1'b0, 1'b0, 1'b0, m_ptr));
                  exp_q.push_back(mk_ev(1'b0, '0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1,
                                        m_ptr + 64'(bq.size())));
                  m_ptr <= m_ptr + 64'(bq.size());
               end
            end
         end
      end
   end

   // Compare: every cycle, mid-period.
   always @(negedge clk) begin
      ev_t e;
      if (check_en) begin
         if (exp_q.size() > 0) e = exp_q.pop_front();
         else e = mk_ev(1'b0, '0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, m_ptr);
         chk("wr_en", 64'(wr_en), 64'(e.we));
         if (e.we) chk("wr_addr", wr_addr, e.addr);
         chk("wr_data", 64'(wr_data), 64'(e.data));
         chk("done", 64'(done), 64'(e.dn));
         chk("instr_err", 64'(instr_err), 64'(e.ierr));
         chk("mem_err", 64'(mem_err), 64'(e.merr));
         chk("next_addr", next_addr, e.nxt);
         chk("in_ready", 64'(in_ready), 64'(e.rdy && !base_load));
         chk("dbg_state", 64'(dbg_state), 64'(e.we));
         if (wr_en === 1'b1) begin
            wr_cnt++;
            mem_img[longint'(wr_addr)] = wr_data;
            wcyc[longint'(wr_addr)]    = cyc;
         end
         if (done === 1'b1)      done_cnt++;
         if (instr_err === 1'b1) ierr_cnt++;
         if (mem_err === 1'b1)   merr_cnt++;
      end
   end

   task automatic send(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                       input logic [3:0] rb, input logic [63:0] vc);
      int n;
      @(negedge clk); #1;
      icode = ic; ifun = fn; rA = ra; rB = rb; valC = vc; in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk); #1;
         n++;
      end
      if (n >= 50) begin
         n_vec++;
         n_err++;
         $display("FAIL send_timeout: in_ready low for %0d cycles, required 1", n);
      end
      @(posedge clk);
   endtask

   task automatic drop();
      @(negedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic load_base(input logic [63:0] a);
      @(negedge clk); #1;
      base_load = 1'b1; base_addr = a;
      @(negedge clk); #1;
      base_load = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int d0, w0;
      rst = 1'b1; base_load = 1'b0; base_addr = '0; in_valid = 1'b0;
      icode = '0; ifun = '0; rA = '0; rB = '0; valC = '0;
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("rst_wr_en", 64'(wr_en), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_next_addr", next_addr, 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);

      // irmovq $0x100, %rsp at 0
      send(4'h3, 4'h0, 4'hF, 4'h4, 64'h100); drop(); idle(14);
      chk("t1_b0", 64'(mem_img[0]), 64'h30);
      chk("t1_b1", 64'(mem_img[1]), 64'hF4);
      chk("t1_b2", 64'(mem_img[2]), 64'h00);
      chk("t1_b3", 64'(mem_img[3]), 64'h01);
      chk("t1_b9", 64'(mem_img[9]), 64'h00);
      chk("t1_span", 64'(wcyc[9] - wcyc[0]), 64'd9);
      chk("t1_next", next_addr, 64'd10);
      chk("t1_wr_cnt", 64'(wr_cnt), 64'd10);
      chk("t1_done_cnt", 64'(done_cnt), 64'd1);

      // call 0x2D from base 23
      load_base(64'd23);
      send(4'h8, 4'h0, 4'h0, 4'h0, 64'h2D); drop(); idle(12);
      chk("t2_b23", 64'(mem_img[23]), 64'h80);
      chk("t2_b24", 64'(mem_img[24]), 64'h2D);
      chk("t2_b31", 64'(mem_img[31]), 64'h00);
      chk("t2_next", next_addr, 64'd32);
      chk("t2_wr_cnt", 64'(wr_cnt), 64'd19);

      // nop then halt back to back
      send(4'h1, 4'h0, 4'h0, 4'h0, 64'h0);
      send(4'h0, 4'h0, 4'h0, 4'h0, 64'h0); drop(); idle(5);
      chk("t3_b32", 64'(mem_img[32]), 64'h10);
      chk("t3_b33", 64'(mem_img[33]), 64'h00);
      chk("t3_gap", 64'(wcyc[33] - wcyc[32]), 64'd2);
      chk("t3_next", next_addr, 64'd34);
      chk("t3_done_cnt", 64'(done_cnt), 64'd4);

      // illegal icode
      send(4'hC, 4'h0, 4'h0, 4'h0, 64'h0); drop(); idle(4);
      chk("t4_ierr_cnt", 64'(ierr_cnt), 64'd1);
      chk("t4_wr_cnt", 64'(wr_cnt), 64'd21);
      chk("t4_next", next_addr, 64'd34);
      chk("t4_in_ready", 64'(in_ready), 64'd1);

      // overrun at the top of memory, then a 1-byte fit
      load_base(64'd2045);
      send(4'h3, 4'h0, 4'hF, 4'h4, 64'h100); drop(); idle(4);
      chk("t5_merr_cnt", 64'(merr_cnt), 64'd1);
      chk("t5_wr_cnt", 64'(wr_cnt), 64'd21);
      chk("t5_next_hold", next_addr, 64'd2045);
      send(4'h1, 4'h0, 4'h0, 4'h0, 64'h0); drop(); idle(4);
      chk("t5_b2045", 64'(mem_img[2045]), 64'h10);
      chk("t5_next", next_addr, 64'd2046);

      // mixed lengths: pushq, popq, ret, jXX, mrmovq, OPq from base 100
      load_base(64'd100);
      send(4'hA, 4'h0, 4'h3, 4'hF, 64'h0);
      send(4'hB, 4'h0, 4'h5, 4'hF, 64'h0);
      send(4'h9, 4'h0, 4'h0, 4'h0, 64'h0);
      send(4'h7, 4'h2, 4'h0, 4'h0, 64'h0123456789ABCDEF);
      send(4'h5, 4'h0, 4'h2, 4'h3, 64'hFEDCBA9876543210);
      send(4'h6, 4'h1, 4'h1, 4'h2, 64'h0); drop(); idle(6);
      chk("t6_b100", 64'(mem_img[100]), 64'hA0);
      chk("t6_b101", 64'(mem_img[101]), 64'h3F);
      chk("t6_b104", 64'(mem_img[104]), 64'h90);
      chk("t6_b105", 64'(mem_img[105]), 64'h72);
      chk("t6_b106", 64'(mem_img[106]), 64'hEF);
      chk("t6_b113", 64'(mem_img[113]), 64'h01);
      chk("t6_b114", 64'(mem_img[114]), 64'h50);
      chk("t6_b115", 64'(mem_img[115]), 64'h23);
      chk("t6_b116", 64'(mem_img[116]), 64'h10);
      chk("t6_b123", 64'(mem_img[123]), 64'hFE);
      chk("t6_b125", 64'(mem_img[125]), 64'h12);
      chk("t6_next", next_addr, 64'd126);

      // reset after the third byte of an irmovq
      d0 = done_cnt; w0 = wr_cnt;
      send(4'h3, 4'h0, 4'hF, 4'h4, 64'h55);
      drop();
      idle(2); #1;
      rst = 1'b1;
      @(negedge clk); #1;
      rst = 1'b0;
      idle(4);
      chk("t7_done_cnt", 64'(done_cnt - d0), 64'd0);
      chk("t7_wr_cnt", 64'(wr_cnt - w0), 64'd3);
      chk("t7_next", next_addr, 64'd0);
      chk("t7_in_ready", 64'(in_ready), 64'd1);
      send(4'hA, 4'h0, 4'h3, 4'hF, 64'h0); drop(); idle(4);
      chk("t7_b0", 64'(mem_img[0]), 64'hA0);
      chk("t7_b1", 64'(mem_img[1]), 64'h3F);
      chk("t7_next2", next_addr, 64'd2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/imem_writer.md
Name: imem_writer

Overview:
- Serializes decoded Y86-64 instruction fields (icode, ifun, rA, rB, valC) into the byte stream that the fetch stage reads back.
- Emits the bytes one per cycle on a byte-wide instruction-memory write port.
- Sits between a testbench/loader front end and the instruction byte array, so programs can be loaded field-wise instead of hand-coding bytes.
- Byte layout matches fetch exactly: byte0 = {icode,ifun}; byte1 = {rA,rB} where present; valC little-endian.

Parameters:
ADDR_W, 64, width of byte address / write pointer
MEM_BYTES, 2048, instruction memory size in bytes; bound for overrun check

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
base_load  in  1  load write pointer from base_addr (honoured only in IDLE)
base_addr  in  ADDR_W  new write pointer value
in_valid  in  1  instruction fields valid
in_ready  out  1  block can accept; = (state==IDLE) && !base_load
icode  in  4  instruction code
ifun  in  4  function code
rA  in  4  register A specifier
rB  in  4  register B specifier
valC  in  64  constant word
wr_en  out  1  memory byte write strobe
wr_addr  out  ADDR_W  byte address
wr_data  out  8  byte value
done  out  1  one-cycle pulse coincident with last byte of an instruction
instr_err  out  1  one-cycle pulse: rejected icode > 0xB
mem_err  out  1  one-cycle pulse: rejected, would exceed MEM_BYTES
next_addr  out  ADDR_W  current write pointer (address of next instruction)

Behaviour:
- Reset: state IDLE; wr_en, done, instr_err, mem_err = 0; wr_addr, wr_data, next_addr = 0; latched fields cleared. in_ready = 1 in the cycle after reset deasserts.
- rst asserted mid-EMIT abandons the instruction: wr_en = 0 from the next cycle, no done pulse, pointer = 0.
- Length by icode:
  - 0 (halt), 1 (nop), 9 (ret): 1 byte.
  - 2 (cmovXX), 6 (OPq), A (pushq), B (popq): 2 bytes.
  - 7 (jXX), 8 (call): 9 bytes; byte0, then valC[7:0] through valC[63:56].
  - 3 (irmovq), 4 (rmmovq), 5 (mrmovq): 10 bytes; byte0, byte1, then valC LE at bytes 2..9.
- States: IDLE, EMIT.
- IDLE:
  - base_load=1: next_addr <= base_addr; no accept that cycle.
  - Handshake at edge T (in_valid & in_ready), checked in priority order:
    - icode > 0xB: instr_err=1 in cycle T+1; no writes; pointer unchanged; stay IDLE.
    - next_addr + len > MEM_BYTES: mem_err=1 in cycle T+1; no writes; stay IDLE. Compare in ADDR_W+1 bits so there is no wrap.
    - Otherwise: latch fields, byte index k=0, go to EMIT.
- EMIT (registered outputs):
  - Cycles T+1 .. T+len: wr_en=1, wr_addr=next_addr+k, wr_data=byte k; k increments each cycle.
  - Cycle T+len: done=1; next_addr <= next_addr+len; state returns to IDLE.
  - in_ready=0 and base_load is ignored throughout EMIT.
  - Throughput is one instruction per len+1 cycles.
- wr_data for bytes never produced is don't-care while wr_en=0, but is driven 0.
- ifun, rA, rB are written unchecked; rA/rB = 0xF (none) is legal.

Decomposition:
- Package y86_pkg: icode localparams (I_HALT..I_POPQ), length constants (1/2/9/10), function instr_len(icode) returning a 4-bit length, function icode_valid(icode).
- One sub-module, instr_byte_sel (combinational): latched fields + k -> byte value. This keeps the layout in one place, mirroring fetch.

Test Plan:
- rst, base 0; irmovq icode3 ifun0 rA=F rB=4 valC=0x100 -> writes 30,F4,00,01,00,00,00,00,00,00 at addr 0..9 on cycles T+1..T+10; done on 10th write; next_addr=10.
- base_load 23; call valC=0x2D -> 80,2D,00×7 at 23..31; done at T+9; next_addr=32.
- Back-to-back nop then halt from base 32 (in_valid held) -> 10@32, then 00@33, each with done; second accept exactly 2 cycles after first; next_addr=34.
- icode=0xC -> instr_err pulse at T+1, wr_en never high, next_addr unchanged, in_ready stays 1.
- base 2045, irmovq -> mem_err pulse, no writes; then nop -> 10@2045, next_addr=2046.
- rst after 3rd byte of irmovq -> wr_en low next cycle, no done, next_addr=0, in_ready=1.
